data_memory_unit: RTL and testbench



---
 rtl/data_memory_unit.sv | 151 +++++++++++++++
 tb/tb_data_memory_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// data_memory_unit
// Word-addressed data memory sitting after the ALU in a single-cycle MIPS
// datapath. Serves byte, halfword and word loads and stores with
// little-endian lane placement. Misaligned or out-of-range accesses are
// flagged. Stores that fault are dropped. The first faulting address is
// captured in a sticky register.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears array and registers
//   inpAddress     byte address (ALU result)
//   inpWriteData   store data
//   inpMemRead     load enable
//   inpMemWrite    store enable
//   inpSize        00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   inpSignExt     1 = sign-extend sub-word loads
//   outReadData    combinational load result (0 unless valid load)
//   outMisaligned  combinational misalignment flag
//   outOutOfRange  combinational range flag
//   outErrorSticky registered, set on first fault
//   outErrorAddr   registered, address of first fault
//   outStoreCount  registered, saturating count of committed stores
module data_memory_unit #(
   parameter int DEPTH_WORDS = 256,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            inpAddress,
   input  logic [31:0]            inpWriteData,
   input  logic                   inpMemRead,
   input  logic                   inpMemWrite,
   input  logic [1:0]             inpSize,
   input  logic                   inpSignExt,
   output logic [31:0]            outReadData,
   output logic                   outMisaligned,
   output logic                   outOutOfRange,
   output logic                   outErrorSticky,
   output logic [31:0]            outErrorAddr,
   output logic [COUNT_WIDTH-1:0] outStoreCount
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]            mem_q [DEPTH_WORDS];
   logic                   err_sticky_q;
   logic [31:0]            err_addr_q;
   logic [COUNT_WIDTH-1:0] store_count_q, store_count_d;

   logic          active;
   logic          fault;
   logic          store_commit;
   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [31:0]   rd_word;
   logic [31:0]   wr_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   read_data;

   assign active   = inpMemRead | inpMemWrite;
   assign word_idx = inpAddress[AW+1:2];
   assign lane     = inpAddress[1:0];
   assign rd_word  = mem_q[word_idx];

   // Any address bit above the array's byte range makes the access out of
   // range; this is the full 32-bit compare, so high addresses never alias.
   assign outOutOfRange = active && ((inpAddress >> (AW + 2)) != 32'd0);

   assign outMisaligned = active &&
                          (((inpSize == 2'b01) && inpAddress[0]) ||
                           ((inpSize == 2'b10) && (lane != 2'b00)) ||
                           (inpSize == 2'b11));

   assign fault        = outMisaligned | outOutOfRange;
   assign store_commit = inpMemWrite & ~fault;

   // Load path: lane select, then extension.
   always_comb begin
      byte_sel = 8'h00;
      case (lane)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
      read_data = 32'h0;
      if (inpMemRead && !fault) begin
         case (inpSize)
            2'b00:   read_data = inpSignExt ? {{24{byte_sel[7]}}, byte_sel}
                                            : {24'h0, byte_sel};
            2'b01:   read_data = inpSignExt ? {{16{half_sel[15]}}, half_sel}
                                            : {16'h0, half_sel};
            2'b10:   read_data = rd_word;
            default: read_data = 32'h0;
         endcase
      end
   end

   assign outReadData = read_data;

   // Store path: merge new lanes into the current word, keep the rest.
   always_comb begin
      wr_word = rd_word;
      case (inpSize)
         2'b00: begin
            case (lane)
               2'd0:    wr_word[7:0]   = inpWriteData[7:0];
               2'd1:    wr_word[15:8]  = inpWriteData[7:0];
               2'd2:    wr_word[23:16] = inpWriteData[7:0];
               default: wr_word[31:24] = inpWriteData[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) wr_word[31:16] = inpWriteData[15:0];
            else         wr_word[15:0]  = inpWriteData[15:0];
         end
         2'b10:   wr_word = inpWriteData;
         default: wr_word = rd_word;
      endcase
   end

   always_comb begin
      store_count_d = store_count_q;
      if (store_commit && (store_count_q != {COUNT_WIDTH{1'b1}}))
         store_count_d = store_count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
         err_sticky_q  <= 1'b0;
         err_addr_q    <= 32'h0;
         store_count_q <= '0;
      end else begin
         if (store_commit) mem_q[word_idx] <= wr_word;
         store_count_q <= store_count_d;
         // Only the first fault is recorded; later ones leave the address.
         if (fault && !err_sticky_q) begin
            err_sticky_q <= 1'b1;
            err_addr_q   <= inpAddress;
         end
      end
   end

   assign outErrorSticky = err_sticky_q;
   assign outErrorAddr   = err_addr_q;
   assign outStoreCount  = store_count_q;

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata;
   logic        mem_read, mem_write, sign_ext;
   logic [1:0]  size;
   logic [31:0] read_data;
   logic        misaligned, out_of_range, err_sticky;
   logic [31:0] err_addr;
   logic [15:0] store_count;

   // second instance with a narrow counter for saturation
   logic        s_reset;
   logic [31:0] s_addr, s_wdata;
   logic        s_read, s_write, s_sign_ext;
   logic [1:0]  s_size;
   logic [31:0] s_read_data;
   logic        s_misaligned, s_out_of_range, s_err_sticky;
   logic [31:0] s_err_addr;
   logic [1:0]  s_store_count;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   data_memory_unit #(.DEPTH_WORDS(256), .COUNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .inpAddress(addr), .inpWriteData(wdata),
      .inpMemRead(mem_read), .inpMemWrite(mem_write), .inpSize(size),
      .inpSignExt(sign_ext), .outReadData(read_data),
      .outMisaligned(misaligned), .outOutOfRange(out_of_range),
      .outErrorSticky(err_sticky), .outErrorAddr(err_addr),
      .outStoreCount(store_count)
   );

   data_memory_unit #(.DEPTH_WORDS(256), .COUNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset(s_reset), .inpAddress(s_addr), .inpWriteData(s_wdata),
      .inpMemRead(s_read), .inpMemWrite(s_write), .inpSize(s_size),
      .inpSignExt(s_sign_ext), .outReadData(s_read_data),
      .outMisaligned(s_misaligned), .outOutOfRange(s_out_of_range),
      .outErrorSticky(s_err_sticky), .outErrorAddr(s_err_addr),
      .outStoreCount(s_store_count)
   );

   // Drive one access for the upcoming cycle (call right after a negedge).
   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr,
                        input logic [1:0] sz, input logic se);
      addr = a; wdata = d; mem_read = rd; mem_write = wr;
      size = sz; sign_ext = se;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; idle();
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (err_sticky !== 1'b0) $display("FAIL reset_sticky got=%0b exp=0", err_sticky);
      else passed++;
      checks++;
      if (err_addr !== 32'h0) $display("FAIL reset_err_addr got=%h exp=0", err_addr);
      else passed++;
      checks++;
      if (store_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", store_count);
      else passed++;
      checks++;
      if (read_data !== 32'h0) $display("FAIL reset_idle_rdata got=%h exp=0", read_data);
      else passed++;
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0) $display("FAIL reset_load got=%h exp=0", read_data);
      else passed++;
   endtask

   task automatic test_word_store_load();
      @(negedge clk);
      drive(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'hDEADBEEF) $display("FAIL word_load got=%h exp=deadbeef", read_data);
      else passed++;
      checks++;
      if (store_count !== 16'd1) $display("FAIL word_count got=%0d exp=1", store_count);
      else passed++;
      checks++;
      if (err_sticky !== 1'b0) $display("FAIL word_sticky got=%0b exp=0", err_sticky);
      else passed++;
   endtask

   task automatic test_byte_store();
      @(negedge clk);
      drive(32'h10, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h13, 32'hFFFFFF80, 1'b0, 1'b1, 2'b00, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b1);
      #1;
      checks++;
      if (read_data !== 32'h80223344) $display("FAIL byte_merge got=%h exp=80223344", read_data);
      else passed++;
      drive(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
      #1;
      checks++;
      if (read_data !== 32'hFFFFFF80) $display("FAIL lb got=%h exp=ffffff80", read_data);
      else passed++;
      drive(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h00000080) $display("FAIL lbu got=%h exp=00000080", read_data);
      else passed++;
      drive(32'h11, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
      #1;
      checks++;
      if (read_data !== 32'h00000033) $display("FAIL lb_lane1 got=%h exp=00000033", read_data);
      else passed++;
      checks++;
      if (store_count !== 16'd3) $display("FAIL byte_count got=%0d exp=3", store_count);
      else passed++;
   endtask

   task automatic test_halfword();
      @(negedge clk);
      drive(32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
      #1;
      checks++;
      if (read_data !== 32'hFFFF8022) $display("FAIL lh got=%h exp=ffff8022", read_data);
      else passed++;
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h00003344) $display("FAIL lhu got=%h exp=00003344", read_data);
      else passed++;
      // halfword store into upper lanes, lower lanes kept
      drive(32'h12, 32'h0000A5B6, 1'b0, 1'b1, 2'b01, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'hA5B63344) $display("FAIL sh_merge got=%h exp=a5b63344", read_data);
      else passed++;
   endtask

   task automatic test_read_before_write();
      @(negedge clk);
      drive(32'h10, 32'hCAFEF00D, 1'b1, 1'b1, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'hA5B63344) $display("FAIL rbw_old got=%h exp=a5b63344", read_data);
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'hCAFEF00D) $display("FAIL rbw_new got=%h exp=cafef00d", read_data);
      else passed++;
      checks++;
      if (store_count !== 16'd5) $display("FAIL rbw_count got=%0d exp=5", store_count);
      else passed++;
   endtask

   task automatic test_misaligned();
      @(negedge clk);
      drive(32'h22, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0);
      #1;
      checks++;
      if ({misaligned, out_of_range} !== 2'b10) $display("FAIL mis_flags got=%b exp=10", {misaligned, out_of_range});
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (err_sticky !== 1'b1) $display("FAIL mis_sticky got=%0b exp=1", err_sticky);
      else passed++;
      checks++;
      if (err_addr !== 32'h22) $display("FAIL mis_err_addr got=%h exp=00000022", err_addr);
      else passed++;
      checks++;
      if (store_count !== 16'd5) $display("FAIL mis_count got=%0d exp=5", store_count);
      else passed++;
      @(negedge clk);
      drive(32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0) $display("FAIL mis_mem got=%h exp=0", read_data);
      else passed++;
      // misaligned halfword load returns 0
      drive(32'h11, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
      #1;
      checks++;
      if ({misaligned, read_data} !== {1'b1, 32'h0}) $display("FAIL mis_lh got=%b/%h exp=1/0", misaligned, read_data);
      else passed++;
      // reserved size faults
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
      #1;
      checks++;
      if ({misaligned, read_data} !== {1'b1, 32'h0}) $display("FAIL rsvd_size got=%b/%h exp=1/0", misaligned, read_data);
      else passed++;
      // later out-of-range fault keeps the first address
      drive(32'h401, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (err_addr !== 32'h22) $display("FAIL later_fault got=%h exp=00000022", err_addr);
      else passed++;
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      drive(32'h400, 32'hFFFFFFFF, 1'b0, 1'b1, 2'b10, 1'b0);
      #1;
      checks++;
      if ({misaligned, out_of_range} !== 2'b01) $display("FAIL oor_flags got=%b exp=01", {misaligned, out_of_range});
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0) $display("FAIL oor_no_wrap got=%h exp=0", read_data);
      else passed++;
      checks++;
      if (store_count !== 16'd5) $display("FAIL oor_count got=%0d exp=5", store_count);
      else passed++;
      // inactive access never flags
      drive(32'h400, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0);
      #1;
      checks++;
      if ({misaligned, out_of_range} !== 2'b00) $display("FAIL idle_flags got=%b exp=00", {misaligned, out_of_range});
      else passed++;
      // high address bit set must not alias
      drive(32'h80000010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if ({out_of_range, read_data} !== {1'b1, 32'h0}) $display("FAIL high_addr got=%b/%h exp=1/0", out_of_range, read_data);
      else passed++;
      // last word is in range
      drive(32'h3FC, 32'h0BADF00D, 1'b0, 1'b1, 2'b10, 1'b0);
      #1;
      checks++;
      if (out_of_range !== 1'b0) $display("FAIL last_word_flag got=%0b exp=0", out_of_range);
      else passed++;
      @(posedge clk); #1;
      @(negedge clk);
      drive(32'h3FC, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0BADF00D) $display("FAIL last_word got=%h exp=0badf00d", read_data);
      else passed++;
      checks++;
      if (store_count !== 16'd6) $display("FAIL last_count got=%0d exp=6", store_count);
      else passed++;
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      reset = 1'b1;
      drive(32'h30, 32'h0000ABCD, 1'b0, 1'b1, 2'b10, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b0;
      drive(32'h30, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0) $display("FAIL rstp_store got=%h exp=0", read_data);
      else passed++;
      drive(32'h10, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      checks++;
      if (read_data !== 32'h0) $display("FAIL rstp_clear got=%h exp=0", read_data);
      else passed++;
      checks++;
      if ({err_sticky, store_count} !== 17'h0) $display("FAIL rstp_regs got=%0b/%0d exp=0/0", err_sticky, store_count);
      else passed++;
      checks++;
      if (err_addr !== 32'h0) $display("FAIL rstp_err_addr got=%h exp=0", err_addr);
      else passed++;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      @(negedge clk);
      s_reset = 1'b1;
      s_read = 1'b0; s_write = 1'b0; s_size = 2'b10; s_sign_ext = 1'b0;
      s_addr = 32'h0; s_wdata = 32'h0;
      @(posedge clk); #1;
      @(negedge clk);
      s_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_addr = 32'(i * 4); s_wdata = 32'(i + 1); s_write = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (s_store_count !== exp_cnt[i]) $display("FAIL sat_count_%0d got=%0d exp=%0d", i, s_store_count, exp_cnt[i]);
         else passed++;
         @(negedge clk);
      end
      s_write = 1'b0;
   endtask

   initial begin
      reset = 1'b1; s_reset = 1'b1;
      idle();
      s_read = 1'b0; s_write = 1'b0; s_size = 2'b10; s_sign_ext = 1'b0;
      s_addr = 32'h0; s_wdata = 32'h0;
      test_reset();
      test_word_store_load();
      test_byte_store();
      test_halfword();
      test_read_before_write();
      test_misaligned();
      test_out_of_range();
      test_reset_priority();
      test_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
